seg_scan_decoder: RTL

- Receive-side counterpart of the six-digit seven-segment scan driver: samples the multiplexed sel/dig bus, decodes each active-low segment pattern back to a 4-bit digit code, and reassembles complete six-digit frames.
- Used for loopback self-test of the display path and for reading a scanned display bus from another board.
- Updates its outputs only on a complete, in-order frame (digit 0 through digit 5).

---
 rtl/seg_scan_decoder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Purpose : rebuilds six-digit frames from a scanned active-low sel/dig seven-segment bus.
// Latency : frame_valid rises 2 + SETTLE_CYC + 1 cycles after the last dig edge of digit 5.
// Backpres: none; the bus is sampled free-running and a frame is dropped if it is not in order.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sel[5:0]           active-low one-hot scan select (bit i low = digit i)
//   dig[7:0]           active-low segment pattern, bit 7 = decimal point
//   out0..out5[3:0]    committed digit codes
//   frame_valid        one-cycle pulse when out0..out5 update
//   frame_err          one-cycle pulse when a frame is aborted
//   bad_seg            level, last committed frame held an unknown pattern
//   scan_lost          level, no sel activity for TIMEOUT_MAX cycles

module seg_scan_decoder #(
   parameter logic [9:0]  SETTLE_CYC  = 10'd4,
   parameter logic [15:0] TIMEOUT_MAX = 16'd9999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] sel,
   input  logic [7:0] dig,
   output logic [3:0] out0,
   output logic [3:0] out1,
   output logic [3:0] out2,
   output logic [3:0] out3,
   output logic [3:0] out4,
   output logic [3:0] out5,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       bad_seg,
   output logic       scan_lost
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t      state, state_nx;

   logic [5:0]  sel_m, s_sel, sel_p;
   logic [7:0]  dig_m, s_dig, dig_p;
   logic        sel_chg, any_chg;
   logic [9:0]  settle_cnt;
   logic        strobe;
   logic [15:0] to_cnt;
   logic        to_hit;

   logic [5:0]  sel_act;
   logic        one_hot;
   logic [2:0]  idx;
   logic [3:0]  code;
   logic        cap;

   logic [2:0]  last;
   logic [2:0]  last_nx1;
   logic [3:0]  shadow [6];
   logic        bad_any;

   logic        store, commit, err;

   // Sync flops idle at all-ones (nothing selected, all segments off)
   // so a quiet bus after reset does not look like a change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_m <= '1;
         s_sel <= '1;
         sel_p <= '1;
         dig_m <= '1;
         s_dig <= '1;
         dig_p <= '1;
      end else begin
         sel_m <= sel;
         s_sel <= sel_m;
         sel_p <= s_sel;
         dig_m <= dig;
         s_dig <= dig_m;
         dig_p <= s_dig;
      end
   end

   assign sel_chg = (s_sel != sel_p);
   assign any_chg = sel_chg || (s_dig != dig_p);

   // Settle counter: one strobe per stable window, when the count reaches
   // SETTLE_CYC and the bus is still unchanged this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         settle_cnt <= '0;
      else if (any_chg)
         settle_cnt <= '0;
      else if (settle_cnt != '1)
         settle_cnt <= settle_cnt + 10'd1;
   end

   assign strobe = !any_chg && (settle_cnt == SETTLE_CYC);

   // Activity timeout; to_hit is the single cycle the count arrives at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (sel_chg)
         to_cnt <= '0;
      else if (to_cnt != TIMEOUT_MAX)
         to_cnt <= to_cnt + 16'd1;
   end

   assign to_hit = !sel_chg && (to_cnt == TIMEOUT_MAX - 16'd1);

   // Slot index from the single low bit of s_sel.
   assign sel_act = ~s_sel;
   assign one_hot = (sel_act != 6'd0) && ((sel_act & (sel_act - 6'd1)) == 6'd0);

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 6; i++)
         if (sel_act[i])
            idx = 3'(i);
   end

   function automatic logic [3:0] seg_decode(input logic [7:0] p);
      logic [3:0] c;
      case (p)
         8'hc0:   c = 4'h0;
         8'hf9:   c = 4'h1;
         8'ha4:   c = 4'h2;
         8'hb0:   c = 4'h3;
         8'h99:   c = 4'h4;
         8'h92:   c = 4'h5;
         8'h82:   c = 4'h6;
         8'hf8:   c = 4'h7;
         8'h80:   c = 4'h8;
         8'h90:   c = 4'h9;
         8'h00:   c = 4'hF;
         default: c = 4'hE;
      endcase
      return c;
   endfunction

   assign code = seg_decode(s_dig);

   // A timeout in the same cycle wins over the capture.
   assign cap      = strobe && one_hot && !to_hit;
   assign last_nx1 = last + 3'd1;

   // 4'hE is only ever produced for an unknown pattern, so the shadow
   // contents themselves serve as the per-slot bad marks.
   assign bad_any = (code == 4'hE) || (shadow[0] == 4'hE) || (shadow[1] == 4'hE) ||
                    (shadow[2] == 4'hE) || (shadow[3] == 4'hE) || (shadow[4] == 4'hE);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      if (to_hit) begin
         state_nx = IDLE;
      end else if (cap) begin
         case (state)
            IDLE:    if (idx == 3'd0) state_nx = COLLECT;
            COLLECT: begin
               if (idx == last_nx1)
                  state_nx = (idx == 3'd5) ? IDLE : COLLECT;
               else if (idx == last)
                  state_nx = COLLECT;
               else
                  state_nx = (idx == 3'd0) ? COLLECT : IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // FSM outputs: shadow write, commit and abort controls
   always_comb begin
      store  = 1'b0;
      commit = 1'b0;
      err    = 1'b0;
      if (cap) begin
         case (state)
            IDLE:    store = (idx == 3'd0);
            COLLECT: begin
               if (idx == last_nx1) begin
                  store  = 1'b1;
                  commit = (idx == 3'd5);
               end else if (idx == last) begin
                  store = 1'b1;
               end else begin
                  err   = 1'b1;
                  store = (idx == 3'd0);
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow, committed outputs and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++)
            shadow[i] <= 4'd0;
         last        <= 3'd0;
         out0        <= 4'd0;
         out1        <= 4'd0;
         out2        <= 4'd0;
         out3        <= 4'd0;
         out4        <= 4'd0;
         out5        <= 4'd0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         bad_seg     <= 1'b0;
         scan_lost   <= 1'b0;
      end else begin
         frame_valid <= commit;
         frame_err   <= err;

         if (to_hit) begin
            for (int i = 0; i < 6; i++)
               shadow[i] <= 4'd0;
            last <= 3'd0;
         end else begin
            if (err)
               for (int i = 0; i < 6; i++)
                  shadow[i] <= 4'd0;
            if (store) begin
               shadow[idx] <= code;
               last        <= idx;
            end
         end

         // Slot 5 goes straight from the decoder into out5 on commit.
         if (commit) begin
            out0    <= shadow[0];
            out1    <= shadow[1];
            out2    <= shadow[2];
            out3    <= shadow[3];
            out4    <= shadow[4];
            out5    <= code;
            bad_seg <= bad_any;
         end

         if (sel_chg)
            scan_lost <= 1'b0;
         else if (to_hit)
            scan_lost <= 1'b1;
      end
   end

endmodule
